// File: rtl/enha_rate_ctrl.sv
// enha_rate_ctrl: per-block pixel attenuation with a double-buffered rate table.
// Pixels are tracked by raster position, tagged with a block index, and scaled
// by the rate that was active for their block when they were accepted.
// The result appears two cycles after the pixel is accepted.
module enha_rate_ctrl #(
    parameter int BLK_W = 8,
    parameter int BLK_H = 8,
    parameter int BLK_X = 4,
    parameter int BLK_Y = 4
) (
    input  logic       iODCK,
    input  logic       iRST,
    input  logic       iVS,
    input  logic       iDE,
    input  logic [7:0] iBpixel,
    input  logic       iCfgWe,
    input  logic [3:0] iCfgAddr,
    input  logic [1:0] iCfgRate,
    output logic       oDE,
    output logic [7:0] oBlockData,
    output logic [3:0] oBlkIdx,
    output logic       oFrameDone,
    output logic       oFrameErr
);

    localparam int NBLK = BLK_X * BLK_Y;
    localparam int PXW  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int BXW  = (BLK_X > 1) ? $clog2(BLK_X) : 1;
    localparam int PYW  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int BYW  = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;

    localparam logic [PXW-1:0] PX_MAX = PXW'(BLK_W - 1);
    localparam logic [BXW-1:0] BX_MAX = BXW'(BLK_X - 1);
    localparam logic [PYW-1:0] PY_MAX = PYW'(BLK_H - 1);
    localparam logic [BYW-1:0] BY_MAX = BYW'(BLK_Y - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Attenuate p by p/2 and/or p/4; the subtracted amount is clamped so the
    // result can never wrap below zero.
    function automatic logic [7:0] atten_fn(input logic [7:0] p, input logic [1:0] r);
        logic [7:0] half;
        logic [7:0] quarter;
        logic [8:0] sum;
        logic [7:0] sub;
        half    = r[1] ? {1'b0, p[7:1]} : 8'h00;
        quarter = r[0] ? {2'b00, p[7:2]} : 8'h00;
        sum     = {1'b0, half} + {1'b0, quarter};
        sub     = sum[8] ? 8'hFF : sum[7:0];
        if (sub > p) begin
            atten_fn = 8'h00;
        end else begin
            atten_fn = p - sub;
        end
    endfunction

    state_e            state_q, state_d;
    logic [PXW-1:0]    px_q, px_d;
    logic [BXW-1:0]    bx_q, bx_d;
    logic [PYW-1:0]    py_q, py_d;
    logic [BYW-1:0]    by_q, by_d;
    logic [15:0][1:0]  shadow_q, shadow_d;
    logic [15:0][1:0]  active_q, active_d;

    logic              s1_vld_q, s1_vld_d;
    logic [7:0]        s1_pix_q, s1_pix_d;
    logic [1:0]        s1_rate_q, s1_rate_d;
    logic [3:0]        s1_idx_q, s1_idx_d;
    logic              s1_last_q, s1_last_d;

    logic              de_q, de_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic              last_s;
    logic [3:0]        blk_idx_s;

    // Frame FSM, raster position counters and the shadow/active rate tables.
    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        bx_d      = bx_q;
        py_d      = py_q;
        by_d      = by_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        accept_s  = (state_q == ST_RUN) && iDE && !iVS;
        last_s    = accept_s && (px_q == PX_MAX) && (bx_q == BX_MAX) &&
                    (py_q == PY_MAX) && (by_q == BY_MAX);
        blk_idx_s = 4'(32'(by_q) * BLK_X + 32'(bx_q));

        case (state_q)
            ST_IDLE: begin
                if (iVS) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (iVS) begin
                    state_d = ST_RUN;
                end else if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (iVS) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (iVS) begin
            px_d = '0;
            bx_d = '0;
            py_d = '0;
            by_d = '0;
        end else if (accept_s) begin
            if (px_q == PX_MAX) begin
                px_d = '0;
                if (bx_q == BX_MAX) begin
                    bx_d = '0;
                    if (py_q == PY_MAX) begin
                        py_d = '0;
                        if (by_q == BY_MAX) begin
                            by_d = '0;
                        end else begin
                            by_d = by_q + 1'b1;
                        end
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end else begin
                px_d = px_q + 1'b1;
            end
        end else begin
            px_d = px_q;
        end

        // The commit takes the shadow contents from before this cycle's write.
        if (iVS) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end

        if (iCfgWe && (32'(iCfgAddr) < NBLK)) begin
            shadow_d[iCfgAddr] = iCfgRate;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Two-stage datapath: stage 1 captures pixel, rate and index; stage 2 attenuates.
    always_comb begin
        s1_vld_d  = accept_s;
        s1_last_d = last_s;
        if (accept_s) begin
            s1_pix_d  = iBpixel;
            s1_rate_d = active_q[blk_idx_s];
            s1_idx_d  = blk_idx_s;
        end else begin
            s1_pix_d  = s1_pix_q;
            s1_rate_d = s1_rate_q;
            s1_idx_d  = s1_idx_q;
        end

        de_d   = s1_vld_q;
        done_d = s1_vld_q && s1_last_q;
        err_d  = (state_q == ST_RUN) && iVS;
        if (s1_vld_q) begin
            data_d = atten_fn(s1_pix_q, s1_rate_q);
            idx_d  = s1_idx_q;
        end else begin
            data_d = data_q;
            idx_d  = idx_q;
        end
    end

    // All state updates, with synchronous reset dominating every other input.
    always_ff @(posedge iODCK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            px_q      <= '0;
            bx_q      <= '0;
            py_q      <= '0;
            by_q      <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_pix_q  <= 8'h00;
            s1_rate_q <= 2'b00;
            s1_idx_q  <= 4'h0;
            s1_last_q <= 1'b0;
            de_q      <= 1'b0;
            data_q    <= 8'h00;
            idx_q     <= 4'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            bx_q      <= bx_d;
            py_q      <= py_d;
            by_q      <= by_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            s1_vld_q  <= s1_vld_d;
            s1_pix_q  <= s1_pix_d;
            s1_rate_q <= s1_rate_d;
            s1_idx_q  <= s1_idx_d;
            s1_last_q <= s1_last_d;
            de_q      <= de_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign oDE        = de_q;
    assign oBlockData = data_q;
    assign oBlkIdx    = idx_q;
    assign oFrameDone = done_q;
    assign oFrameErr  = err_q;

endmodule

// File: tb/tb_enha_rate_ctrl.sv
// Directed bench for enha_rate_ctrl with a two-deep expectation delay line.
module tb_enha_rate_ctrl;

    logic       clk;
    logic       iRST;
    logic       iVS;
    logic       iDE;
    logic [7:0] iBpixel;
    logic       iCfgWe;
    logic [3:0] iCfgAddr;
    logic [1:0] iCfgRate;
    logic       oDE;
    logic [7:0] oBlockData;
    logic [3:0] oBlkIdx;
    logic       oFrameDone;
    logic       oFrameErr;

    int checks;
    int failures;

    // expectation for the inputs driven this cycle, and the two-deep delay line
    logic       cur_de, cur_done, cur_err;
    logic [7:0] cur_data;
    logic [3:0] cur_idx;
    logic       d1_de, d1_done, d2_de, d2_done;
    logic [7:0] d1_data, d2_data, hold_data;
    logic [3:0] d1_idx, d2_idx, hold_idx;

    // expected output for an 8'hFF pixel in each block, set by hand per frame
    logic [7:0] ff_tab [16];
    logic [7:0] alt1_pix [4];
    logic [7:0] alt1_exp [4];
    logic [7:0] alt2_pix [4];
    logic [7:0] alt2_exp [4];

    enha_rate_ctrl dut (
        .iODCK      (clk),
        .iRST       (iRST),
        .iVS        (iVS),
        .iDE        (iDE),
        .iBpixel    (iBpixel),
        .iCfgWe     (iCfgWe),
        .iCfgAddr   (iCfgAddr),
        .iCfgRate   (iCfgRate),
        .oDE        (oDE),
        .oBlockData (oBlockData),
        .oBlkIdx    (oBlkIdx),
        .oFrameDone (oFrameDone),
        .oFrameErr  (oFrameErr)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock, check all outputs, then return inputs to idle.
    task automatic tick();
        logic was_rst;
        was_rst = iRST;
        @(posedge clk);
        #1;
        d2_de = d1_de; d2_data = d1_data; d2_idx = d1_idx; d2_done = d1_done;
        d1_de = cur_de; d1_data = cur_data; d1_idx = cur_idx; d1_done = cur_done;
        if (was_rst) begin
            d1_de = 1'b0; d1_done = 1'b0; d2_de = 1'b0; d2_done = 1'b0;
            hold_data = 8'h00; hold_idx = 4'h0;
            cur_err = 1'b0;
        end
        if (d2_de) begin
            hold_data = d2_data;
            hold_idx  = d2_idx;
        end
        check_eq("oDE", oDE, d2_de);
        check_eq("oBlockData", oBlockData, hold_data);
        check_eq("oBlkIdx", oBlkIdx, hold_idx);
        check_eq("oFrameDone", oFrameDone, d2_done);
        check_eq("oFrameErr", oFrameErr, cur_err);
        iVS = 1'b0; iDE = 1'b0; iCfgWe = 1'b0; iRST = 1'b0;
        cur_de = 1'b0; cur_done = 1'b0; cur_err = 1'b0;
        cur_data = 8'h00; cur_idx = 4'h0;
    endtask

    task automatic drive_px(input logic [7:0] pix, input logic [7:0] exp,
                            input logic [3:0] idx, input logic done);
        iDE = 1'b1; iBpixel = pix;
        cur_de = 1'b1; cur_data = exp; cur_idx = idx; cur_done = done;
        tick();
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [1:0] rate);
        iCfgWe = 1'b1; iCfgAddr = addr; iCfgRate = rate;
        tick();
    endtask

    task automatic pulse_vs(input logic de, input logic err);
        iVS = 1'b1; iDE = de; iBpixel = 8'hFF; cur_err = err;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raster-order pixels: 32 pixels per line, 256 pixels per block row.
    task automatic run_pixels(input int count, input logic alt, input int wr_at,
                              input logic [3:0] wr_addr, input logic [1:0] wr_rate);
        for (int n = 0; n < count; n++) begin
            int line;
            int blk;
            logic [7:0] pix;
            logic [7:0] exp;
            line = (n / 32) % 8;
            blk  = (n / 256) * 4 + (n % 32) / 8;
            pix  = 8'hFF;
            exp  = ff_tab[blk];
            if (alt && blk < 4 && line == 1) begin
                pix = alt1_pix[blk]; exp = alt1_exp[blk];
            end else if (alt && blk < 4 && line == 2) begin
                pix = alt2_pix[blk]; exp = alt2_exp[blk];
            end else begin
                pix = 8'hFF;
            end
            if (n == wr_at) begin
                iCfgWe = 1'b1; iCfgAddr = wr_addr; iCfgRate = wr_rate;
            end
            drive_px(pix, exp, 4'(blk), n == 1023);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        iRST = 1'b1; iVS = 1'b0; iDE = 1'b0; iBpixel = 8'h00;
        iCfgWe = 1'b0; iCfgAddr = 4'h0; iCfgRate = 2'b00;
        cur_de = 1'b0; cur_done = 1'b0; cur_err = 1'b0; cur_data = 8'h00; cur_idx = 4'h0;
        d1_de = 1'b0; d1_done = 1'b0; d1_data = 8'h00; d1_idx = 4'h0;
        d2_de = 1'b0; d2_done = 1'b0; d2_data = 8'h00; d2_idx = 4'h0;
        hold_data = 8'h00; hold_idx = 4'h0;
        // rates 0,1,2,3 applied to hand-picked pixels
        alt1_pix[0] = 8'h5A; alt1_exp[0] = 8'h5A;   // 90
        alt1_pix[1] = 8'h64; alt1_exp[1] = 8'h4B;   // 100-25=75
        alt1_pix[2] = 8'h65; alt1_exp[2] = 8'h33;   // 101-50=51
        alt1_pix[3] = 8'h80; alt1_exp[3] = 8'h20;   // 128-64-32=32
        alt2_pix[0] = 8'h00; alt2_exp[0] = 8'h00;
        alt2_pix[1] = 8'h03; alt2_exp[1] = 8'h03;   // 3-0
        alt2_pix[2] = 8'h01; alt2_exp[2] = 8'h01;   // 1-0
        alt2_pix[3] = 8'h03; alt2_exp[3] = 8'h02;   // 3-1-0
        for (int b = 0; b < 16; b++) ff_tab[b] = 8'hFF;

        // reset state
        tick();
        iRST = 1'b1;
        tick();

        // iDE while IDLE and with iVS is dropped; then a full frame of 8'hFF
        for (int i = 0; i < 3; i++) begin
            iDE = 1'b1; iBpixel = 8'h12;
            tick();
        end
        pulse_vs(1'b1, 1'b0);
        run_pixels(1024, 1'b0, -1, 4'h0, 2'b00);
        iDE = 1'b1; iBpixel = 8'h34;   // lands in DONE, dropped
        tick();
        iDE = 1'b1; iBpixel = 8'h34;   // lands in IDLE, dropped
        tick();
        idle(3);

        // rates 0..3 on blocks 0..3; block 4 written in the iVS cycle stays shadow-only
        cfg_write(4'h0, 2'd0);
        cfg_write(4'h1, 2'd1);
        cfg_write(4'h2, 2'd2);
        cfg_write(4'h3, 2'd3);
        iCfgWe = 1'b1; iCfgAddr = 4'h4; iCfgRate = 2'd3;
        pulse_vs(1'b0, 1'b0);
        ff_tab[0] = 8'hFF; ff_tab[1] = 8'hC0; ff_tab[2] = 8'h80; ff_tab[3] = 8'h41;
        // block 0 set to rate 3 mid-frame: no effect until the next iVS
        run_pixels(1024, 1'b1, 10, 4'h0, 2'd3);
        idle(3);

        // next frame: block 0 and block 4 now rate 3
        pulse_vs(1'b0, 1'b0);
        ff_tab[0] = 8'h41; ff_tab[4] = 8'h41;
        // shadow block 0 back to rate 0 at pixel 98; in-flight pixels keep rate 3
        run_pixels(100, 1'b0, 98, 4'h0, 2'd0);
        pulse_vs(1'b1, 1'b1);          // mid-frame iVS: error pulse, restart
        ff_tab[0] = 8'hFF;
        run_pixels(1024, 1'b0, -1, 4'h0, 2'b00);
        idle(3);

        // reset at pixel 500 with iDE held high
        pulse_vs(1'b0, 1'b0);
        run_pixels(500, 1'b0, -1, 4'h0, 2'b00);
        iRST = 1'b1; iDE = 1'b1; iBpixel = 8'hFF;
        tick();
        for (int i = 0; i < 6; i++) begin
            iDE = 1'b1; iBpixel = 8'hFF;
            tick();
        end

        // tables were cleared by reset: the whole frame passes through unchanged
        for (int b = 0; b < 16; b++) ff_tab[b] = 8'hFF;
        pulse_vs(1'b1, 1'b0);
        run_pixels(1024, 1'b0, -1, 4'h0, 2'b00);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
